// File: rtl/sseg_pkg.sv
// Shared constants, phase encoding and parameter helpers for the seven-segment scan driver.
// Segment vectors are {g,f,e,d,c,b,a}, active low.
package sseg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

  // Classification of the current clock within a digit slot
  typedef enum logic [1:0] {
    PH_DEAD = 2'd0,
    PH_ON   = 2'd1,
    PH_OFF  = 2'd2
  } phase_e;

  function automatic int tick_div(input int clk_hz, input int slot_hz);
    return clk_hz / slot_hz;
  endfunction

endpackage

// File: rtl/sseg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
// Lowercase b and d glyphs so they are distinguishable from 8 and 0.
module sseg_hex_decode
  import sseg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // Glyph lookup
  always_comb begin
    seg = SEG_BLANK;
    case (nib)
      4'h0:    seg = GLYPH_0;
      4'h1:    seg = GLYPH_1;
      4'h2:    seg = GLYPH_2;
      4'h3:    seg = GLYPH_3;
      4'h4:    seg = GLYPH_4;
      4'h5:    seg = GLYPH_5;
      4'h6:    seg = GLYPH_6;
      4'h7:    seg = GLYPH_7;
      4'h8:    seg = GLYPH_8;
      4'h9:    seg = GLYPH_9;
      4'hA:    seg = GLYPH_A;
      4'hB:    seg = GLYPH_B;
      4'hC:    seg = GLYPH_C;
      4'hD:    seg = GLYPH_D;
      4'hE:    seg = GLYPH_E;
      4'hF:    seg = GLYPH_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sseg_mux.sv
// Time-multiplexed common-anode seven-segment driver: one digit per slot, frame-synchronous
// value shadowing, leading-zero blanking and PWM brightness. All outputs are registered.
module sseg_mux
  import sseg_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int CLK_HZ   = 100_000_000,
  parameter int SLOT_HZ  = 1_000,
  parameter int BRIGHT_W = 4
)
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic [BRIGHT_W-1:0]   bright,
  input  logic                  en,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame
);

  localparam int TICK_DIV = tick_div(CLK_HZ, SLOT_HZ);
  localparam int SLOT_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int IDX_W    = $clog2(DIGITS);
  localparam int SHADOW_W = 5 * DIGITS;

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_IDLE   = AN_OFF[DIGITS-1:0];

  logic [SLOT_W-1:0]   slot_cnt_r;
  logic [BRIGHT_W-1:0] pwm_cnt_r;
  logic [IDX_W-1:0]    idx_r;
  logic [IDX_W-1:0]    idx_nxt_s;
  logic [SHADOW_W-1:0] pending_r;
  logic [SHADOW_W-1:0] active_r;
  logic [SHADOW_W-1:0] shadow_in_s;
  logic [4*DIGITS-1:0] active_val_s;
  logic [DIGITS-1:0]   active_dp_s;
  logic                tick_s;
  logic                wrap_s;
  logic [3:0]          nib_s;
  logic [6:0]          glyph_s;
  logic                upper_zero_s;
  logic                blank_s;
  phase_e              phase_s;
  logic [DIGITS-1:0]   an_nxt_s;
  logic [6:0]          seg_r;
  logic                dp_r;
  logic [DIGITS-1:0]   an_r;
  logic                frame_r;

  assign tick_s       = (slot_cnt_r == SLOT_LAST);
  assign wrap_s       = tick_s && (idx_r == IDX_LAST);
  assign shadow_in_s  = {value, dp_in};
  assign active_val_s = active_r[SHADOW_W-1:DIGITS];
  assign active_dp_s  = active_r[DIGITS-1:0];

  // Slot timer and free-running PWM phase
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_cnt_r <= '0;
      pwm_cnt_r  <= '0;
    end else begin
      slot_cnt_r <= tick_s ? '0 : slot_cnt_r + SLOT_W'(1);
      pwm_cnt_r  <= pwm_cnt_r + BRIGHT_W'(1);
    end
  end

  // Digit index next state
  always_comb begin
    idx_nxt_s = idx_r;
    if (tick_s) begin
      if (wrap_s) begin
        idx_nxt_s = '0;
      end else begin
        idx_nxt_s = idx_r + IDX_W'(1);
      end
    end else begin
      idx_nxt_s = idx_r;
    end
  end

  // Digit index register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_r <= '0;
    end else begin
      idx_r <= idx_nxt_s;
    end
  end

  // A load coinciding with the wrap bypasses pending so that frame is not lost
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_r <= '0;
      active_r  <= '0;
    end else begin
      if (load) begin
        pending_r <= shadow_in_s;
      end
      if (wrap_s) begin
        active_r <= load ? shadow_in_s : pending_r;
      end
    end
  end

  assign nib_s = active_val_s[{idx_r, 2'b00} +: 4];

  sseg_hex_decode u_dec (
    .nib (nib_s),
    .seg (glyph_s)
  );

  // Leading-zero detect: the scanned digit and every digit to its left are zero
  always_comb begin
    upper_zero_s = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (i >= int'(idx_r)) begin
        upper_zero_s = upper_zero_s && (active_val_s[4*i +: 4] == 4'h0);
      end else begin
        upper_zero_s = upper_zero_s;
      end
    end
    blank_s = blank_lz && (idx_r != '0) && upper_zero_s;
  end

  // Slot phase; the first clock of every slot is dead to avoid ghosting
  always_comb begin
    phase_s = PH_OFF;
    if (slot_cnt_r == '0) begin
      phase_s = PH_DEAD;
    end else if (en && (pwm_cnt_r < bright)) begin
      phase_s = PH_ON;
    end else begin
      phase_s = PH_OFF;
    end
  end

  // Anode pattern for the next output register
  always_comb begin
    an_nxt_s = AN_IDLE;
    case (phase_s)
      PH_ON:   an_nxt_s[idx_r] = 1'b0;
      PH_DEAD: an_nxt_s = AN_IDLE;
      PH_OFF:  an_nxt_s = AN_IDLE;
      default: an_nxt_s = AN_IDLE;
    endcase
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_r   <= SEG_BLANK;
      dp_r    <= 1'b1;
      an_r    <= AN_IDLE;
      frame_r <= 1'b0;
    end else begin
      seg_r   <= blank_s ? SEG_BLANK : glyph_s;
      dp_r    <= ~active_dp_s[idx_r];
      an_r    <= an_nxt_s;
      frame_r <= wrap_s;
    end
  end

  assign seg   = seg_r;
  assign dp    = dp_r;
  assign an    = an_r;
  assign frame = frame_r;

endmodule
